noc_link_monitor: RTL and testbench



---
 rtl/noc_mon_pkg.sv | 15 +
 rtl/noc_link_counter.sv | 64 ++++++
 rtl/noc_link_monitor.sv | 155 +++++++++++++++
 tb/tb_noc_link_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mon_pkg.sv
// Shared definitions for the NoC link monitor.
//   noc_mon_state_t : snapshot streamer states
//   NOC_MON_MAGIC   : marker byte at the top of every frame header
package noc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    CNT  = 2'd2,
    ALM  = 2'd3
  } noc_mon_state_t;

  localparam logic [7:0] NOC_MON_MAGIC = 8'hA5;

endpackage

// File: rtl/noc_link_counter.sv
// Per-link statistics: saturating flit and packet counters, a stall run
// counter and the sticky stall alarm.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid, ready, last  : link taps
//   clr_cnt             : restart flit/pkt counters (an event this cycle counts as 1)
//   alarm_clr           : clear the alarm (a coincident set wins)
//   flits, pkts         : live counter values
//   alarm               : sticky stall alarm
module noc_link_counter
  import noc_mon_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 ready,
  input  logic                 last,
  input  logic                 clr_cnt,
  input  logic                 alarm_clr,
  output logic [CNT_WIDTH-1:0] flits,
  output logic [CNT_WIDTH-1:0] pkts,
  output logic                 alarm
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

  logic [STALL_W-1:0] stall;
  logic               xfer;
  logic               stalled;
  logic               alarm_set;

  assign xfer    = valid & ready;
  assign stalled = valid & ~ready;
  // Fires on the stalled cycle that brings the run up to the limit, so the
  // alarm becomes visible together with stall == LIMIT.
  assign alarm_set = stalled && (stall == LIMIT - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flits <= '0;
      pkts  <= '0;
      stall <= '0;
      alarm <= 1'b0;
    end else begin
      if (clr_cnt) begin
        flits <= {{(CNT_WIDTH-1){1'b0}}, xfer};
        pkts  <= {{(CNT_WIDTH-1){1'b0}}, xfer & last};
      end else begin
        if (xfer && (flits != '1)) flits <= flits + 1'b1;
        if (xfer && last && (pkts != '1)) pkts <= pkts + 1'b1;
      end

      if (!stalled)            stall <= '0;
      else if (stall != LIMIT) stall <= stall + 1'b1;

      alarm <= alarm_set | (alarm & ~alarm_clr);
    end
  end

endmodule

// File: rtl/noc_link_monitor.sv
// NoC link monitor: counts flits/packets and detects stalls on LINKS links,
// and on request streams a frozen snapshot of all counters as a frame:
//   header {A5, LINKS, seq}, flits[0], pkts[0], ..., pkts[LINKS-1], alarm map.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   link_valid/link_ready/link_last    : per-link taps
//   snap_req                           : snapshot request (honoured in IDLE only)
//   snap_busy                          : frame in progress
//   alarm, alarm_clr                   : sticky stall alarms and their clears
//   out_data/out_valid/out_ready/out_last : frame stream
//   dbg_state                          : streamer state
// Stream handshake: a word moves on a cycle with out_valid & out_ready; while
// out_valid is high and out_ready low, out_valid/out_data/out_last hold.
// Requires 1 <= LINKS <= CNT_WIDTH and STALL_LIMIT >= 1. For CNT_WIDTH <= 16
// the header keeps only its top CNT_WIDTH bits (magic first).
module noc_link_monitor
  import noc_mon_pkg::*;
#(
  parameter int LINKS         = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int STALL_LIMIT   = 1024,
  parameter int CLEAR_ON_SNAP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LINKS-1:0]     link_valid,
  input  logic [LINKS-1:0]     link_ready,
  input  logic [LINKS-1:0]     link_last,
  input  logic                 snap_req,
  output logic                 snap_busy,
  output logic [LINKS-1:0]     alarm,
  input  logic [LINKS-1:0]     alarm_clr,
  output logic [CNT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output noc_mon_state_t       dbg_state
);

  localparam int IW    = $clog2(2 * LINKS);
  localparam int SEQ_W = (CNT_WIDTH > 16) ? CNT_WIDTH - 16 : 1;

  noc_mon_state_t       state;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        next_idx;
  logic [CNT_WIDTH-1:0] next_word;
  logic [CNT_WIDTH-1:0] seq;
  logic [CNT_WIDTH-1:0] live_flits [LINKS];
  logic [CNT_WIDTH-1:0] live_pkts  [LINKS];
  logic [CNT_WIDTH-1:0] sh_flits   [LINKS];
  logic [CNT_WIDTH-1:0] sh_pkts    [LINKS];
  logic [LINKS-1:0]     sh_alarm;
  logic [15+SEQ_W:0]    hdr_wide;
  logic [CNT_WIDTH-1:0] header;
  logic                 snap_go;
  logic                 clr_cnt;

  assign snap_go = (state == IDLE) && snap_req;
  assign clr_cnt = (CLEAR_ON_SNAP != 0) && snap_go;

  for (genvar g = 0; g < LINKS; g++) begin : g_link
    noc_link_counter #(
      .CNT_WIDTH   (CNT_WIDTH),
      .STALL_LIMIT (STALL_LIMIT)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (link_valid[g]),
      .ready     (link_ready[g]),
      .last      (link_last[g]),
      .clr_cnt   (clr_cnt),
      .alarm_clr (alarm_clr[g]),
      .flits     (live_flits[g]),
      .pkts      (live_pkts[g]),
      .alarm     (alarm[g])
    );
  end

  assign hdr_wide  = {NOC_MON_MAGIC, 8'(LINKS), seq[SEQ_W-1:0]};
  assign header    = hdr_wide[15+SEQ_W -: CNT_WIDTH];
  assign snap_busy = (state != IDLE);
  assign dbg_state = state;

  // Counter word that follows word idx: even indices are flits, odd are pkts.
  always_comb begin
    next_idx  = idx + 1'b1;
    next_word = '0;
    for (int i = 0; i < LINKS; i++) begin
      if (next_idx == IW'(2 * i))     next_word = sh_flits[i];
      if (next_idx == IW'(2 * i + 1)) next_word = sh_pkts[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      seq       <= '0;
      sh_alarm  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < LINKS; i++) begin
        sh_flits[i] <= '0;
        sh_pkts[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            for (int i = 0; i < LINKS; i++) begin
              sh_flits[i] <= live_flits[i];
              sh_pkts[i]  <= live_pkts[i];
            end
            sh_alarm  <= alarm;
            seq       <= seq + 1'b1;
            out_data  <= header;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            out_data <= sh_flits[0];
            idx      <= '0;
            state    <= CNT;
          end
        end
        CNT: begin
          if (out_ready) begin
            if (idx == IW'(2 * LINKS - 1)) begin
              out_data <= CNT_WIDTH'(sh_alarm);
              out_last <= 1'b1;
              state    <= ALM;
            end else begin
              idx      <= next_idx;
              out_data <= next_word;
            end
          end
        end
        ALM: begin
          if (out_ready) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_link_monitor.sv
// Bench for noc_link_monitor: instance A (4 links, 32-bit, stall limit 8)
// and instance B (2 links, 8-bit, stall limit 4, clear on snapshot).
module tb_noc_link_monitor;

  localparam int LA = 4, WA = 32, SLA = 8;
  localparam int LB = 2, WB = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic [LA-1:0] a_valid, a_ready, a_last, a_clr, a_alarm;
  logic          a_snap, a_busy, a_ovalid, a_oready, a_olast;
  logic [WA-1:0] a_data;
  noc_mon_pkg::noc_mon_state_t a_state;

  noc_link_monitor #(.LINKS(LA), .CNT_WIDTH(WA), .STALL_LIMIT(SLA), .CLEAR_ON_SNAP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .link_valid(a_valid), .link_ready(a_ready),
    .link_last(a_last), .snap_req(a_snap), .snap_busy(a_busy), .alarm(a_alarm),
    .alarm_clr(a_clr), .out_data(a_data), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_last(a_olast), .dbg_state(a_state)
  );

  // ---------------- DUT B ----------------
  logic [LB-1:0] b_valid, b_ready, b_last, b_clr, b_alarm;
  logic          b_snap, b_busy, b_ovalid, b_oready, b_olast;
  logic [WB-1:0] b_data;
  noc_mon_pkg::noc_mon_state_t b_state;

  noc_link_monitor #(.LINKS(LB), .CNT_WIDTH(WB), .STALL_LIMIT(4), .CLEAR_ON_SNAP(1)) u_b (
    .clk(clk), .rst_n(rst_n), .link_valid(b_valid), .link_ready(b_ready),
    .link_last(b_last), .snap_req(b_snap), .snap_busy(b_busy), .alarm(b_alarm),
    .alarm_clr(b_clr), .out_data(b_data), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_last(b_olast), .dbg_state(b_state)
  );

  // ---------------- scoreboard / check ----------------
  logic [WA:0] exp_q[$];   // {last, data}
  logic [WB:0] exp_b[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model of A ----------------
  logic [WA-1:0] m_flits[LA];
  logic [WA-1:0] m_pkts[LA];
  int            m_stall[LA];
  logic [LA-1:0] m_alarm;
  logic [WA-1:0] m_seq;
  int            bp_mode = 0;
  int            bp_idx = 0;
  logic          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int            hs_cnt = 0;

  task automatic model_reset();
    for (int i = 0; i < LA; i++) begin
      m_flits[i] = '0;
      m_pkts[i]  = '0;
      m_stall[i] = 0;
    end
    m_alarm = '0;
    m_seq   = '0;
  endtask

  // Apply the current A inputs for one clock; the model consumes the same inputs.
  task automatic tick();
    logic set;
    if (bp_mode != 0) begin
      a_oready = bp_pat[bp_idx % 4];
      bp_idx++;
    end else begin
      a_oready = 1'b1;
    end
    for (int i = 0; i < LA; i++) begin
      set = 1'b0;
      if (a_valid[i] && a_ready[i]) begin
        if (m_flits[i] != '1) m_flits[i]++;
        if (a_last[i] && m_pkts[i] != '1) m_pkts[i]++;
      end
      if (a_valid[i] && !a_ready[i]) begin
        if (m_stall[i] < SLA) begin
          m_stall[i]++;
          if (m_stall[i] == SLA) set = 1'b1;
        end
      end else begin
        m_stall[i] = 0;
      end
      m_alarm[i] = set | (m_alarm[i] & ~a_clr[i]);
    end
    @(posedge clk);
    #1;
  endtask

  // Request a snapshot on A (caller guarantees A is idle) and queue its frame.
  task automatic snap_a();
    a_snap = 1'b1;
    exp_q.push_back({1'b0, 8'hA5, 8'd4, m_seq[15:0]});
    for (int i = 0; i < LA; i++) begin
      exp_q.push_back({1'b0, m_flits[i]});
      exp_q.push_back({1'b0, m_pkts[i]});
    end
    exp_q.push_back({1'b1, 28'd0, m_alarm});
    m_seq++;
    tick();
    a_snap = 1'b0;
    check("snap_valid_rise", a_ovalid, 1);
    check("snap_busy_rise", a_busy, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((a_busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("frame_done", {a_busy, exp_q.size() != 0}, 0);
  endtask

  // ---------------- output monitors ----------------
  logic        held = 1'b0;
  logic [WA:0] held_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", a_ovalid, 1);
        check("hold_word", {a_olast, a_data}, held_word);
      end
      if (a_ovalid && a_oready) begin
        if (exp_q.size() == 0) check("extra_word_a", {a_olast, a_data}, 0);
        else check("word_a", {a_olast, a_data}, exp_q.pop_front());
        hs_cnt++;
        held = 1'b0;
      end else if (a_ovalid) begin
        held = 1'b1;
        held_word = {a_olast, a_data};
      end else begin
        held = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ovalid && b_oready) begin
      if (exp_b.size() == 0) check("extra_word_b", {b_olast, b_data}, 0);
      else check("word_b", {b_olast, b_data}, exp_b.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    a_valid = '0; a_ready = '0; a_last = '0; a_clr = '0; a_snap = 1'b0; a_oready = 1'b1;
    b_valid = '0; b_ready = '0; b_last = '0; b_clr = '0; b_snap = 1'b0; b_oready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", a_ovalid, 0);
    check("rst_out_last", a_olast, 0);
    check("rst_snap_busy", a_busy, 0);
    check("rst_out_data", a_data, 0);
    check("rst_alarm", a_alarm, 0);
    check("rst_b_valid", b_ovalid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counting: 10 transfers on link 2, last on every 5th.
    for (int k = 0; k < 10; k++) begin
      a_valid = 4'b0100;
      a_ready = 4'b0100;
      a_last  = (k % 5 == 4) ? 4'b0100 : 4'b0000;
      tick();
    end
    a_valid = '0; a_ready = '0; a_last = '0;
    snap_a();
    wait_idle(n);
    check("frame_cycles", n, 2 * LA + 2);

    // Stall alarm on link 1.
    a_valid = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("alarm_pre", a_alarm, m_alarm);
    end
    a_ready = 4'b0010;
    tick();
    check("alarm_after_7", a_alarm, 0);
    a_ready = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alarm_run", a_alarm, m_alarm);
    end
    check("alarm_set", a_alarm, 4'b0010);
    a_valid = '0; a_ready = 4'b0010;
    tick();
    check("alarm_sticky", a_alarm, 4'b0010);
    a_ready = '0; a_clr = 4'b0010;
    tick();
    a_clr = '0;
    check("alarm_clr", a_alarm, 0);

    // Backpressure frame, ignored request while busy, live counting meanwhile.
    bp_mode = 1;
    snap_a();
    repeat (3) tick();
    a_snap = 1'b1;
    a_valid = 4'b0001; a_ready = 4'b0001;
    tick();
    a_snap = 1'b0;
    check("busy_during_ignored", a_busy, 1);
    wait_idle(n);
    a_valid = '0; a_ready = '0;
    bp_mode = 0;
    repeat (4) tick();
    check("no_extra_frame", a_busy, 0);

    // Alarm on link 3, then set/clear collision, then a frame carrying it.
    a_valid = 4'b1000;
    repeat (8) tick();
    a_valid = '0;
    tick();
    a_valid = 4'b1000;
    repeat (7) tick();
    a_clr = 4'b1000;
    tick();
    a_clr = '0; a_valid = '0;
    check("set_wins", a_alarm, 4'b1000);
    snap_a();
    wait_idle(n);

    // Instance B: saturation at 8 bits and clear-on-snapshot.
    for (int k = 0; k < 300; k++) begin
      b_valid = 2'b01; b_ready = 2'b01;
      @(posedge clk);
      #1;
    end
    b_snap = 1'b1;
    exp_b.push_back({1'b0, 8'hA5});
    exp_b.push_back({1'b0, 8'd255});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b1, 8'd0});
    @(posedge clk);
    #1;
    b_snap = 1'b0; b_valid = '0; b_ready = '0;
    for (int k = 0; k < 40 && (b_busy || exp_b.size() != 0); k++) @(posedge clk);
    #1;
    check("b_frame1_done", {b_busy, exp_b.size() != 0}, 0);
    b_snap = 1'b1;
    exp_b.push_back({1'b0, 8'hA5});
    exp_b.push_back({1'b0, 8'd1});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b0, 8'd0});
    exp_b.push_back({1'b1, 8'd0});
    @(posedge clk);
    #1;
    b_snap = 1'b0;
    for (int k = 0; k < 40 && (b_busy || exp_b.size() != 0); k++) @(posedge clk);
    #1;
    check("b_frame2_done", {b_busy, exp_b.size() != 0}, 0);

    // Reset in the middle of a frame, at word 3.
    a_valid = 4'b0001; a_ready = 4'b0001;
    tick();
    a_valid = '0; a_ready = '0;
    base = hs_cnt;
    snap_a();
    for (int k = 0; k < 20 && hs_cnt < base + 3; k++) begin
      @(negedge clk);
      #1;
    end
    check("reached_word3", hs_cnt - base, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", a_ovalid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_last", a_olast, 0);
    check("midrst_alarm", a_alarm, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", a_busy, 0);
    snap_a();
    wait_idle(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
